// File: rtl/evict_buffer.sv
// rtl/evict_buffer.sv - write-back victim buffer between cache and physical memory
//
// Purpose: absorbs dirty-line write-backs into a small FIFO and acknowledges
// them immediately. The FIFO drains to memory whenever memory is otherwise
// idle. Reads that hit a buffered line are answered from the buffer; read
// misses go straight to memory and take priority over starting a drain.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   cache_read/cache_write        line request from cache, held until cache_resp
//   cache_address/cache_wdata     request address and write line
//   cache_resp/cache_rdata        one-cycle completion pulse and read line
//   pmem_read/pmem_write          memory request, held until pmem_resp
//   pmem_address/pmem_wdata       memory address and write line
//   pmem_resp/pmem_rdata          memory completion pulse and read line
//   buf_empty                     no buffered lines and no memory cycle in flight
module evict_buffer #(
  parameter int DEPTH            = 4,
  parameter int LINE_OFFSET_BITS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cache_read,
  input  logic         cache_write,
  input  logic [15:0]  cache_address,
  input  logic [127:0] cache_wdata,
  output logic         cache_resp,
  output logic [127:0] cache_rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic         pmem_resp,
  input  logic [127:0] pmem_rdata,
  output logic         buf_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TAG_W = 16 - LINE_OFFSET_BITS;

  typedef enum logic [1:0] {IDLE, RD, WR} state_e;

  state_e             state_q, state_d;
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q  [DEPTH];
  logic [127:0]       data_q [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               cache_resp_q, cache_resp_d;
  logic [127:0]       cache_rdata_q, cache_rdata_d;
  logic               pmem_read_q, pmem_read_d;
  logic               pmem_write_q, pmem_write_d;
  logic [15:0]        pmem_address_q, pmem_address_d;
  logic [127:0]       pmem_wdata_q, pmem_wdata_d;
  logic               buf_empty_q, buf_empty_d;

  logic [TAG_W-1:0]   req_tag;
  logic               eval, full;
  logic               rd_hit, wr_hit, head_hazard;
  logic [PTR_W-1:0]   rd_idx, wr_idx;
  logic               miss_go, alloc, coalesce, retire;

  assign req_tag = cache_address[15:LINE_OFFSET_BITS];
  // The request is ignored during its own resp cycle, and while in RD the
  // held read is the one already being serviced by memory.
  assign eval    = !cache_resp_q && (state_q != RD);
  assign full    = (count_q == CNT_W'(DEPTH));

  always_comb begin
    rd_hit      = 1'b0;
    rd_idx      = '0;
    wr_hit      = 1'b0;
    wr_idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (tag_q[i] == req_tag)) begin
        rd_hit = 1'b1;
        rd_idx = PTR_W'(i);
        // The head being written to memory must not change under the drain.
        if (!((state_q == WR) && (PTR_W'(i) == head_q))) begin
          wr_hit = 1'b1;
          wr_idx = PTR_W'(i);
        end
      end
    end
    head_hazard = (state_q == WR) && valid_q[head_q] && (tag_q[head_q] == req_tag);
  end

  always_comb begin
    state_d        = state_q;
    valid_d        = valid_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    cache_resp_d   = 1'b0;
    cache_rdata_d  = cache_rdata_q;
    pmem_read_d    = pmem_read_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;
    miss_go        = 1'b0;
    alloc          = 1'b0;
    coalesce       = 1'b0;
    retire         = 1'b0;

    if (eval && cache_read) begin
      if (rd_hit) begin
        cache_resp_d  = 1'b1;
        cache_rdata_d = data_q[rd_idx];
      end else if (state_q == IDLE) begin
        miss_go = 1'b1;
      end
    end else if (eval && cache_write) begin
      if (head_hazard) begin
        // wait for the head to retire, then the write allocates fresh
      end else if (wr_hit) begin
        coalesce     = 1'b1;
        cache_resp_d = 1'b1;
      end else if (!full) begin
        alloc        = 1'b1;
        cache_resp_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (miss_go) begin
          state_d        = RD;
          pmem_read_d    = 1'b1;
          pmem_address_d = cache_address;
        end else if (count_q != '0) begin
          state_d        = WR;
          pmem_write_d   = 1'b1;
          pmem_address_d = {tag_q[head_q], {LINE_OFFSET_BITS{1'b0}}};
          // A write coalescing into the head this same cycle must reach memory.
          pmem_wdata_d   = (coalesce && (wr_idx == head_q)) ? cache_wdata : data_q[head_q];
        end
      end
      RD: begin
        if (pmem_resp) begin
          state_d       = IDLE;
          pmem_read_d   = 1'b0;
          cache_rdata_d = pmem_rdata;
          cache_resp_d  = 1'b1;
        end
      end
      WR: begin
        if (pmem_resp) begin
          state_d      = IDLE;
          pmem_write_d = 1'b0;
          retire       = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (retire) valid_d[head_q] = 1'b0;
    if (alloc)  valid_d[tail_q] = 1'b1;
    head_d      = head_q + PTR_W'(retire);
    tail_d      = tail_q + PTR_W'(alloc);
    count_d     = count_q + CNT_W'(alloc) - CNT_W'(retire);
    buf_empty_d = (count_d == '0) && (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      valid_q        <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      cache_resp_q   <= 1'b0;
      cache_rdata_q  <= '0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
      buf_empty_q    <= 1'b1;
    end else begin
      state_q        <= state_d;
      valid_q        <= valid_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      cache_resp_q   <= cache_resp_d;
      cache_rdata_q  <= cache_rdata_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
      buf_empty_q    <= buf_empty_d;
    end
  end

  // Line storage is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (alloc) begin
      tag_q[tail_q]  <= req_tag;
      data_q[tail_q] <= cache_wdata;
    end else if (coalesce) begin
      data_q[wr_idx] <= cache_wdata;
    end
  end

  assign cache_resp   = cache_resp_q;
  assign cache_rdata  = cache_rdata_q;
  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;
  assign buf_empty    = buf_empty_q;

endmodule
